rs_stream_encoder: RTL and testbench

Streaming, clocked, systematic Reed-Solomon encoder over GF(16), primitive polynomial x^4+x+1. It replaces the one-shot RS(15,9) encoder, which takes the whole message in parallel, with a symbol-serial, parametrised design. The parity count and message length are parameters, so shortened codes are supported, and valid/ready handshakes on both sides allow backpressure. It sits between the message source and the channel/modulator, and emits each codeword as K message symbols followed by NSYM parity symbols.

---
 rtl/rs_gf16_pkg.sv | 42 ++++
 rtl/rs_lfsr_stage.sv | 26 ++
 rtl/rs_stream_encoder.sv | 112 +++++++++++
 tb/tb_rs_stream_encoder.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/rs_gf16_pkg.sv
// GF(16) arithmetic (x^4+x+1) and Reed-Solomon generator construction shared by the stream encoder.
package rs_gf16_pkg;

   typedef logic [3:0] gf16_t;

   localparam logic [4:0] PRIM_POLY = 5'b10011;
   localparam int         MAX_NSYM  = 6;

   // Coefficients g0..g6, g0 in element 0.
   typedef gf16_t [MAX_NSYM:0] genPoly_t;

   typedef enum logic [1:0] {IDLE, MSG, PAR} encState_t;

   function automatic gf16_t gf_mul(input gf16_t a, input gf16_t b);
      logic [6:0] prod;
      prod = '0;
      for (int i = 0; i < 4; i++)
         if (b[i]) prod = prod ^ (7'(a) << i);
      for (int i = 6; i >= 4; i--)
         if (prod[i]) prod = prod ^ (7'(PRIM_POLY) << (i - 4));
      return prod[3:0];
   endfunction

   // Expands prod(x + alpha^i), i = 1..nsym, one root at a time.
   function automatic genPoly_t gen_poly(input int nsym);
      genPoly_t g;
      gf16_t    root;
      g    = '0;
      g[0] = 4'h1;
      root = 4'h1;
      for (int i = 1; i <= MAX_NSYM; i++) begin
         if (i <= nsym) begin
            root = gf_mul(root, 4'h2);
            for (int j = MAX_NSYM; j > 0; j--)
               g[j] = g[j-1] ^ gf_mul(g[j], root);
            g[0] = gf_mul(g[0], root);
         end
      end
      return g;
   endfunction

endpackage

// File: rtl/rs_lfsr_stage.sv
// One parity register of the RS encoder LFSR: q <= fb*COEF ^ prev when enabled.
// Single-cycle update; holds when en is low, clr wins over en.
module rs_lfsr_stage
   import rs_gf16_pkg::*;
#(
   parameter logic [3:0] COEF = 4'h1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       clr,
   input  logic [3:0] fb,
   input  logic [3:0] prev,
   output logic [3:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         q <= '0;
      else if (clr)
         q <= '0;
      else if (en)
         q <= gf_mul(fb, COEF) ^ prev;
   end

endmodule

// File: rtl/rs_stream_encoder.sv
// Symbol-serial systematic RS encoder over GF(16): zero-latency message passthrough, then NSYM parity symbols.
// Stalls on s_valid/m_ready; optional abort input under RS_ENC_ABORT_EN.
module rs_stream_encoder
   import rs_gf16_pkg::*;
#(
   parameter int NSYM = 6,
   parameter int K    = 9
) (
   input  logic        clk,
   input  logic        rst_n,
`ifdef RS_ENC_ABORT_EN
   input  logic        abort,
`endif
   input  logic        s_valid,
   output logic        s_ready,
   input  logic [3:0]  s_data,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [3:0]  m_data,
   output logic        m_last,
   output logic        busy,
   output logic [15:0] cw_count
);

   localparam genPoly_t   GEN    = gen_poly(NSYM);
   localparam logic [3:0] K_LAST = 4'(K - 1);
   localparam logic [3:0] P_LAST = 4'(NSYM - 1);

   encState_t  state;
   logic [3:0] symCnt;
   gf16_t      par [NSYM];
   gf16_t      fb;
   logic       inXfer;
   logic       outXfer;
   logic       lfsrEn;
   logic       abortReq;

`ifdef RS_ENC_ABORT_EN
   assign abortReq = abort;
`else
   assign abortReq = 1'b0;
`endif

   // Handshake outputs are gated by rst_n so nothing looks valid/ready while in reset.
   assign s_ready = rst_n && m_ready && (state != PAR);
   assign m_valid = rst_n && ((state == PAR) || s_valid);
   assign m_data  = !m_valid ? 4'h0 : (state == PAR) ? par[NSYM-1] : s_data;
   assign m_last  = rst_n && (state == PAR) && (symCnt == P_LAST) && !abortReq;
   assign busy    = (state != IDLE);

   assign inXfer  = s_valid && s_ready;
   assign outXfer = m_valid && m_ready;
   assign lfsrEn  = (state == PAR) ? outXfer : inXfer;
   assign fb      = (state == MSG)  ? (s_data ^ par[NSYM-1]) :
                    (state == IDLE) ? s_data : 4'h0;

   // In IDLE the chain inputs are forced to zero, so the first symbol loads a clean LFSR.
   for (genvar j = 0; j < NSYM; j++) begin : gStage
      gf16_t prevSym;
      if (j == 0) begin : gFirst
         assign prevSym = 4'h0;
      end else begin : gChain
         assign prevSym = (state == IDLE) ? 4'h0 : par[j-1];
      end
      rs_lfsr_stage #(.COEF(GEN[j])) uStage (
         .clk   (clk),
         .rst_n (rst_n),
         .en    (lfsrEn),
         .clr   (abortReq),
         .fb    (fb),
         .prev  (prevSym),
         .q     (par[j])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         symCnt   <= '0;
         cw_count <= '0;
      end else if (abortReq) begin
         state  <= IDLE;
         symCnt <= '0;
      end else begin
         case (state)
            IDLE: if (inXfer) begin
               state  <= (K == 1) ? PAR : MSG;
               symCnt <= (K == 1) ? 4'h0 : 4'h1;
            end
            MSG: if (inXfer) begin
               if (symCnt == K_LAST) begin
                  state  <= PAR;
                  symCnt <= '0;
               end else begin
                  symCnt <= symCnt + 4'h1;
               end
            end
            PAR: if (outXfer) begin
               if (symCnt == P_LAST) begin
                  state    <= IDLE;
                  symCnt   <= '0;
                  cw_count <= cw_count + 16'h1;
               end else begin
                  symCnt <= symCnt + 4'h1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rs_stream_encoder.sv
// Directed-vector bench for rs_stream_encoder with NSYM=6, K=9.
module tb_rs_stream_encoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        s_valid;
   logic        s_ready;
   logic [3:0]  s_data;
   logic        m_valid;
   logic        m_ready;
   logic [3:0]  m_data;
   logic        m_last;
   logic        busy;
   logic [15:0] cw_count;
`ifdef RS_ENC_ABORT_EN
   logic        abort = 1'b0;
`endif

   always #5 clk = ~clk;

   rs_stream_encoder #(.NSYM(6), .K(9)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
`ifdef RS_ENC_ABORT_EN
      .abort    (abort),
`endif
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .s_data   (s_data),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_data   (m_data),
      .m_last   (m_last),
      .busy     (busy),
      .cw_count (cw_count)
   );

   typedef struct {
      logic [0:8][3:0] msg;
      logic [0:5][3:0] par;
   } vec_t;

   vec_t vecs [7];
   int   nRun  = 0;
   int   nFail = 0;
   int   expCw = 0;

   task automatic check(input string what, input int act, input int exp);
      nRun++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %0h, expected %0h", what, act, exp);
      end
   endtask

   // Streams one codeword through the DUT and scores every output handshake.
   task automatic run_cw(input logic [0:8][3:0] msg, input logic [0:5][3:0] par,
                         input bit stall, input int id);
      logic [3:0] expSym [15];
      int         sent     = 0;
      int         got      = 0;
      int         cyc      = 0;
      logic       prevHold = 1'b0;
      logic [3:0] prevDat  = 4'h0;
      for (int i = 0; i < 9; i++) expSym[i] = msg[i];
      for (int i = 0; i < 6; i++) expSym[9+i] = par[i];
      while (got < 15 && cyc < 400) begin
         @(negedge clk);
         cyc++;
         s_valid = (sent < 9) && (!stall || $urandom_range(1, 0) == 1);
         s_data  = (sent < 9) ? msg[sent] : 4'h0;
         m_ready = !stall || ($urandom_range(1, 0) == 1);
         #1;
         if (prevHold && m_valid)
            check($sformatf("cw%0d hold", id), int'(m_data), int'(prevDat));
         if (!m_valid)
            check($sformatf("cw%0d data idle", id), int'(m_data), 0);
         if (sent == 9)
            check($sformatf("cw%0d s_ready in parity", id), int'(s_ready), 0);
         if (m_valid && m_ready) begin
            check($sformatf("cw%0d sym%0d", id, got), int'(m_data), int'(expSym[got]));
            check($sformatf("cw%0d last%0d", id, got), int'(m_last), int'(got == 14));
            got++;
         end
         if (s_valid && s_ready) sent++;
         prevHold = m_valid && !m_ready;
         prevDat  = m_data;
      end
      if (got < 15) begin
         nRun++;
         nFail++;
         $display("FAIL cw%0d timeout: got %0d symbols, expected 15", id, got);
      end
      if (!stall) check($sformatf("cw%0d cycles", id), cyc, 15);
      expCw++;
      @(posedge clk);
      #1;
      check($sformatf("cw%0d cw_count", id), int'(cw_count), expCw);
      check($sformatf("cw%0d busy after", id), int'(busy), 0);
   endtask

   initial begin
      // message symbol 0 first; parity listed g5-side first
      vecs[0].msg = 36'h0;             vecs[0].par = 24'h000000;
      vecs[1].msg = {32'h0, 4'h1};     vecs[1].par = 24'h793CAC;
      vecs[2].msg = {32'h0, 4'h2};     vecs[2].par = 24'hE16B7B;
      vecs[3].msg = {32'h0, 4'h3};     vecs[3].par = 24'h9857D7;
      vecs[4].msg = {32'h0, 4'h4};     vecs[4].par = 24'hF2C5E5;
      vecs[5].msg = {28'h0, 8'h10};    vecs[5].par = 24'hF958F2;
      vecs[6].msg = {28'h0, 8'h11};    vecs[6].par = 24'h80645E;

      rst_n   = 1'b0;
      s_valid = 1'b1;
      s_data  = 4'hA;
      m_ready = 1'b1;
      @(negedge clk);
      #1;
      check("reset m_valid",  int'(m_valid),  0);
      check("reset s_ready",  int'(s_ready),  0);
      check("reset m_data",   int'(m_data),   0);
      check("reset m_last",   int'(m_last),   0);
      check("reset busy",     int'(busy),     0);
      check("reset cw_count", int'(cw_count), 0);
      @(negedge clk);
      rst_n   = 1'b1;
      s_valid = 1'b0;
      s_data  = 4'h0;

      for (int v = 0; v < 7; v++)
         run_cw(vecs[v].msg, vecs[v].par, 1'b0, v);

      run_cw(vecs[1].msg, vecs[1].par, 1'b1, 10);
      run_cw(vecs[6].msg, vecs[6].par, 1'b1, 11);
      run_cw(vecs[4].msg, vecs[4].par, 1'b1, 12);

      // Reset after five accepted symbols drops the partial codeword.
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         s_valid = 1'b1;
         s_data  = 4'h5;
         m_ready = 1'b1;
      end
      @(negedge clk);
      s_valid = 1'b0;
      #1;
      check("midcw busy", int'(busy), 1);
      s_valid = 1'b1;
      rst_n   = 1'b0;
      #1;
      check("midrst m_valid",  int'(m_valid),  0);
      check("midrst s_ready",  int'(s_ready),  0);
      check("midrst m_data",   int'(m_data),   0);
      check("midrst busy",     int'(busy),     0);
      check("midrst cw_count", int'(cw_count), 0);
      expCw = 0;
      @(negedge clk);
      rst_n   = 1'b1;
      s_valid = 1'b0;
      run_cw(vecs[3].msg, vecs[3].par, 1'b0, 20);

`ifdef RS_ENC_ABORT_EN
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         s_valid = 1'b1;
         s_data  = vecs[2].msg[i];
         m_ready = 1'b1;
      end
      @(negedge clk);
      s_valid = 1'b0;
      #1;
      check("abort par1", int'(m_data), int'(vecs[2].par[0]));
      @(negedge clk);
      abort = 1'b1;
      #1;
      check("abort m_last", int'(m_last), 0);
      @(negedge clk);
      abort = 1'b0;
      #1;
      check("abort busy",     int'(busy),     0);
      check("abort m_valid",  int'(m_valid),  0);
      check("abort cw_count", int'(cw_count), expCw);
      run_cw(vecs[2].msg, vecs[2].par, 1'b0, 30);
`endif

      $display("[TB] %0d tests run, %0d failed", nRun, nFail);
      $finish;
   end

endmodule
